// File: rtl/ghost_dir_picker.sv
// ghost_dir_picker: turns random bytes into a legal movement direction for one
// ghost at a maze intersection. Rejection-samples candidates against the
// allowed set, with a deterministic rotate-scan fallback after MAX_TRIES.
module ghost_dir_picker #(
  parameter int unsigned MAX_TRIES = 4,
  parameter int unsigned RAND_LSB  = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] legal_mask,
  input  logic [1:0] cur_dir,
  input  logic [7:0] rand_in,
  output logic       rand_take,
  output logic [1:0] dir_out,
  output logic       valid,
  output logic       stuck,
  output logic       busy
);

  localparam int unsigned TRY_W = 3;
  localparam int unsigned DIR_W = 2;
  localparam int unsigned NDIR  = 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SAMPLE   = 3'd1,
    S_CHECK    = 3'd2,
    S_FALLBACK = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [NDIR-1:0]    allowed_q, allowed_d;
  logic [DIR_W-1:0]   cand_q, cand_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic               stuck_q, stuck_d;
  logic               valid_q, take_q, busy_q;

  logic [NDIR-1:0]    rev_onehot;
  logic [NDIR-1:0]    no_reverse;
  logic [NDIR-1:0]    start_allowed;
  logic [DIR_W-1:0]   fb_dir;
  logic [DIR_W-1:0]   fb_idx;
  logic               fb_found;
  logic               unused_rand;

  // Only two bits of the random byte feed the candidate.
  assign unused_rand = ^rand_in;

  // Allowed set at start: forbid reversal unless it is the only way out.
  always_comb begin
    rev_onehot    = NDIR'(1) << (cur_dir ^ 2'b10);
    no_reverse    = legal_mask & ~rev_onehot;
    start_allowed = (no_reverse == '0) ? legal_mask : no_reverse;
  end

  // Fallback: first allowed direction rotating upward from the last candidate.
  always_comb begin
    fb_dir   = cand_q;
    fb_found = 1'b0;
    fb_idx   = '0;
    for (int i = 1; i < int'(NDIR); i++) begin
      fb_idx = cand_q + DIR_W'(i);
      if (!fb_found && allowed_q[fb_idx]) begin
        fb_dir   = fb_idx;
        fb_found = 1'b1;
      end
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    allowed_d = allowed_q;
    cand_d    = cand_q;
    tries_d   = tries_q;
    dir_d     = dir_q;
    stuck_d   = stuck_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          allowed_d = start_allowed;
          tries_d   = '0;
          stuck_d   = 1'b0;
          if (legal_mask == '0) begin
            dir_d   = cur_dir;
            stuck_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_SAMPLE;
          end
        end
      end
      S_SAMPLE: begin
        cand_d  = rand_in[RAND_LSB +: DIR_W];
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (allowed_q[cand_q]) begin
          dir_d   = cand_q;
          state_d = S_DONE;
        end else if (tries_q + TRY_W'(1) == TRY_W'(MAX_TRIES)) begin
          state_d = S_FALLBACK;
        end else begin
          tries_d = tries_q + TRY_W'(1);
          state_d = S_SAMPLE;
        end
      end
      S_FALLBACK: begin
        dir_d   = fb_dir;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered output decodes, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      allowed_q <= '0;
      cand_q    <= '0;
      tries_q   <= '0;
      dir_q     <= '0;
      stuck_q   <= 1'b0;
      valid_q   <= 1'b0;
      take_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      allowed_q <= allowed_d;
      cand_q    <= cand_d;
      tries_q   <= tries_d;
      dir_q     <= dir_d;
      stuck_q   <= stuck_d;
      valid_q   <= (state_d == S_DONE);
      take_q    <= (state_d == S_SAMPLE);
      busy_q    <= (state_d != S_IDLE);
    end
  end

  assign rand_take = take_q;
  assign dir_out   = dir_q;
  assign valid     = valid_q;
  assign stuck     = stuck_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ghost_dir_picker.sv
// Directed self-checking bench for ghost_dir_picker (MAX_TRIES=4, RAND_LSB=0).
// Cycle n of a decision is observed 1 time unit after the (n-1)th edge
// following the start edge, i.e. the start edge itself ends cycle 0.
module tb_ghost_dir_picker;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [3:0] legal_mask;
  logic [1:0] cur_dir;
  logic [7:0] rand_in;
  logic       rand_take;
  logic [1:0] dir_out;
  logic       valid;
  logic       stuck;
  logic       busy;

  int total;
  int bad;

  ghost_dir_picker #(.MAX_TRIES(4), .RAND_LSB(0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .legal_mask (legal_mask),
    .cur_dir    (cur_dir),
    .rand_in    (rand_in),
    .rand_take  (rand_take),
    .dir_out    (dir_out),
    .valid      (valid),
    .stuck      (stuck),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one decision: first random byte r0, all later bytes r1.
  // Inputs other than rand_in are scrambled after the start edge.
  task automatic run_decision(input logic [3:0] lm, input logic [1:0] cd,
                              input logic [7:0] r0, input logic [7:0] r1,
                              input int max_cyc,
                              output int vcyc, output logic [1:0] dout,
                              output logic st, output int takes,
                              output int valids, output logic hold_ok);
    vcyc    = -1;
    dout    = 2'bxx;
    st      = 1'bx;
    takes   = 0;
    valids  = 0;
    hold_ok = 1'b1;
    start      = 1'b1;
    legal_mask = lm;
    cur_dir    = cd;
    rand_in    = r0;
    for (int n = 1; n <= max_cyc; n++) begin
      @(posedge clk);
      #1;
      start      = 1'b0;
      legal_mask = 4'($urandom);
      cur_dir    = 2'($urandom);
      rand_in    = (takes == 0) ? r0 : r1;
      if (rand_take === 1'b1) takes++;
      if (valid === 1'b1) begin
        valids++;
        if (vcyc < 0) begin
          vcyc = n;
          dout = dir_out;
          st   = stuck;
        end
      end
      if (busy !== ((vcyc < 0) || (vcyc == n))) hold_ok = 1'b0;
      if (vcyc >= 0 && (dir_out !== dout || stuck !== st)) hold_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0; legal_mask = 4'hF; cur_dir = 2'd1; rand_in = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      total++;
      if ({dir_out, valid, stuck, busy, rand_take} !== 6'b0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d dir=%0d valid=%b stuck=%b busy=%b take=%b expected all 0",
                 n, dir_out, valid, stuck, busy, rand_take);
      end
    end
  endtask

  task automatic test_dead_stop();
    int vc, tk, nv; logic [1:0] d; logic s, h;
    run_decision(4'b0000, 2'd2, 8'h00, 8'h00, 6, vc, d, s, tk, nv, h);
    total++; if (vc !== 1) begin bad++; $display("FAIL lm0_latency got=%0d exp=1", vc); end
    total++; if (d !== 2'd2) begin bad++; $display("FAIL lm0_dir got=%0d exp=2", d); end
    total++; if (s !== 1'b1) begin bad++; $display("FAIL lm0_stuck got=%b exp=1", s); end
    total++; if (tk !== 0) begin bad++; $display("FAIL lm0_takes got=%0d exp=0", tk); end
    total++; if (h !== 1'b1 || nv !== 1) begin bad++; $display("FAIL lm0_hold hold=%b valids=%0d exp 1/1", h, nv); end
  endtask

  task automatic test_first_hit();
    int vc, tk, nv; logic [1:0] d; logic s, h;
    // cd=0 -> reverse 2, allowed=1011; byte 01 -> cand 1 accepted
    run_decision(4'b1011, 2'd0, 8'h01, 8'h01, 8, vc, d, s, tk, nv, h);
    total++; if (vc !== 3) begin bad++; $display("FAIL hit_latency got=%0d exp=3", vc); end
    total++; if (d !== 2'd1) begin bad++; $display("FAIL hit_dir got=%0d exp=1", d); end
    total++; if (s !== 1'b0) begin bad++; $display("FAIL hit_stuck_clear got=%b exp=0", s); end
    total++; if (tk !== 1) begin bad++; $display("FAIL hit_takes got=%0d exp=1", tk); end
    total++; if (h !== 1'b1 || nv !== 1) begin bad++; $display("FAIL hit_hold hold=%b valids=%0d exp 1/1", h, nv); end
    // cd=1 -> reverse 3, allowed=0111; byte FE -> cand 2 (upper bits ignored)
    run_decision(4'b1111, 2'd1, 8'hFE, 8'h00, 8, vc, d, s, tk, nv, h);
    total++; if (vc !== 3) begin bad++; $display("FAIL hit2_latency got=%0d exp=3", vc); end
    total++; if (d !== 2'd2) begin bad++; $display("FAIL hit2_dir got=%0d exp=2", d); end
  endtask

  task automatic test_reverse_excluded();
    int vc, tk, nv; logic [1:0] d; logic s, h;
    // cd=0, lm=0101 -> allowed=0001; cand 2 rejected then cand 0 accepted
    run_decision(4'b0101, 2'd0, 8'h02, 8'h00, 10, vc, d, s, tk, nv, h);
    total++; if (vc !== 5) begin bad++; $display("FAIL rev_latency got=%0d exp=5", vc); end
    total++; if (d !== 2'd0) begin bad++; $display("FAIL rev_dir got=%0d exp=0", d); end
    total++; if (tk !== 2) begin bad++; $display("FAIL rev_takes got=%0d exp=2", tk); end
    total++; if (h !== 1'b1) begin bad++; $display("FAIL rev_busy_hold got=%b exp=1", h); end
  endtask

  task automatic test_dead_end();
    int vc, tk, nv; logic [1:0] d; logic s, h;
    // cd=1, lm=1000: only exit is reversal, so allowed=1000; cand 3 accepted
    run_decision(4'b1000, 2'd1, 8'h03, 8'h03, 8, vc, d, s, tk, nv, h);
    total++; if (vc !== 3) begin bad++; $display("FAIL deadend_latency got=%0d exp=3", vc); end
    total++; if (d !== 2'd3) begin bad++; $display("FAIL deadend_dir got=%0d exp=3", d); end
    total++; if (s !== 1'b0) begin bad++; $display("FAIL deadend_stuck got=%b exp=0", s); end
  endtask

  task automatic test_fallback();
    int vc, tk, nv; logic [1:0] d; logic s, h;
    // cd=3, lm=0110 -> allowed=0100; cand 0 four times, scan 1,2 -> 2
    run_decision(4'b0110, 2'd3, 8'h00, 8'h00, 14, vc, d, s, tk, nv, h);
    total++; if (vc !== 10) begin bad++; $display("FAIL fb_latency got=%0d exp=10", vc); end
    total++; if (d !== 2'd2) begin bad++; $display("FAIL fb_dir got=%0d exp=2", d); end
    total++; if (tk !== 4) begin bad++; $display("FAIL fb_takes got=%0d exp=4", tk); end
    total++; if (h !== 1'b1 || nv !== 1) begin bad++; $display("FAIL fb_hold hold=%b valids=%0d exp 1/1", h, nv); end
    // cd=2, lm=0110 -> allowed=0110; cand 3 four times, scan 0,1 -> 1
    run_decision(4'b0110, 2'd2, 8'h03, 8'h03, 14, vc, d, s, tk, nv, h);
    total++; if (vc !== 10) begin bad++; $display("FAIL fb2_latency got=%0d exp=10", vc); end
    total++; if (d !== 2'd1) begin bad++; $display("FAIL fb2_dir got=%0d exp=1", d); end
  endtask

  task automatic test_start_while_busy();
    int vc, nv, tk;
    logic [1:0] d;
    logic s;
    vc = -1; nv = 0; tk = 0; d = 2'bxx; s = 1'bx;
    start = 1'b1; legal_mask = 4'b0110; cur_dir = 2'd3; rand_in = 8'h00;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk);
      #1;
      // a second request with lm=0 mid-decision must not be taken
      start = (n == 3 || n == 6);
      legal_mask = (n == 3 || n == 6) ? 4'b0000 : 4'b0110;
      cur_dir = 2'd1;
      if (rand_take === 1'b1) tk++;
      if (valid === 1'b1) begin
        nv++;
        if (vc < 0) begin vc = n; d = dir_out; s = stuck; end
      end
    end
    total++; if (vc !== 10 || nv !== 1) begin bad++; $display("FAIL busy_ignore valid_cyc=%0d valids=%0d exp 10/1", vc, nv); end
    total++; if (d !== 2'd2 || s !== 1'b0) begin bad++; $display("FAIL busy_ignore_dir dir=%0d stuck=%b exp 2/0", d, s); end
    total++; if (tk !== 4) begin bad++; $display("FAIL busy_ignore_takes got=%0d exp=4", tk); end
  endtask

  task automatic test_back_to_back();
    int v1, v2, nv;
    logic b4;
    v1 = -1; v2 = -1; nv = 0; b4 = 1'bx;
    start = 1'b1; legal_mask = 4'b1011; cur_dir = 2'd0; rand_in = 8'h01;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      if (n == 8) start = 1'b0;
      if (n == 4) b4 = busy;
      if (valid === 1'b1) begin
        nv++;
        if (v1 < 0) v1 = n; else if (v2 < 0) v2 = n;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    total++; if (v1 !== 3 || v2 !== 7 || nv !== 2) begin bad++; $display("FAIL b2b_valids first=%0d second=%0d n=%0d exp 3/7/2", v1, v2, nv); end
    total++; if (b4 !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap busy=%b exp=0", b4); end
    total++; if (dir_out !== 2'd1) begin bad++; $display("FAIL b2b_dir got=%0d exp=1", dir_out); end
  endtask

  task automatic test_reset_mid();
    int nv;
    nv = 0;
    start = 1'b1; legal_mask = 4'b0101; cur_dir = 2'd0; rand_in = 8'h02;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({dir_out, valid, stuck, busy, rand_take} !== 6'b0) begin
      bad++;
      $display("FAIL reset_mid dir=%0d valid=%b stuck=%b busy=%b take=%b expected all 0",
               dir_out, valid, stuck, busy, rand_take);
    end
    reset_n = 1'b1;
    rand_in = 8'h00;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1 || busy === 1'b1 || rand_take === 1'b1) nv++;
    end
    total++; if (nv !== 0) begin bad++; $display("FAIL reset_mid_abort activity_cycles=%0d exp=0", nv); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    start = 1'b0; legal_mask = '0; cur_dir = '0; rand_in = '0;
    test_reset();
    test_dead_stop();
    test_first_hit();
    test_reverse_excluded();
    test_dead_end();
    test_fallback();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
